// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for a 5-stage RV32 datapath. It keeps a shadow copy of
//   the register-index / write-enable / load information for the E, M and W
//   stages. From that copy it derives:
//     - operand forwarding selects for the E stage,
//     - stall and flush controls for the F/D/E/M/W pipeline registers,
//     - a wait-state FSM that holds the pipeline while a slow data memory
//       finishes an access, abandoning the access after MEM_TIMEOUT cycles.
//   The datapath decode-register enable is driven from ~StallD_o.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   Rs1D_i, Rs2D_i      source register indices of the instruction in D
//   RdD_i, RegWriteD_i  destination index / write enable of the D instruction
//   ResultSrcD_i        D result select; 2'b01 marks a load
//   BranchTakenE_i      taken branch/jump in E redirects the PC
//   MemAccessM_i        load/store present in M
//   MemReadyM_i         data memory completes its access this cycle
//   ForwardAE_o/BE_o    00 RD1E/RD2E, 01 ResultW, 10 ALUResultM
//   StallF_o..StallM_o  hold the corresponding stage register
//   FlushD_o/E_o/W_o    load a bubble into the corresponding stage register
//   mem_err_o           sticky flag: a memory access timed out
//   stall_cnt_o         saturating count of memory-stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D_i,
  input  logic [REG_ADDR_W-1:0] Rs2D_i,
  input  logic [REG_ADDR_W-1:0] RdD_i,
  input  logic                  RegWriteD_i,
  input  logic [1:0]            ResultSrcD_i,
  input  logic                  BranchTakenE_i,
  input  logic                  MemAccessM_i,
  input  logic                  MemReadyM_i,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  StallE_o,
  output logic                  StallM_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic                  FlushW_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // ---------------------------------------------------------------------------
  // Shadow pipeline state
  // ---------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] rs1_e_reg, rs2_e_reg, rd_e_reg;
  logic                  regwrite_e_reg, load_e_reg;
  logic [REG_ADDR_W-1:0] rd_m_reg;
  logic                  regwrite_m_reg;
  logic [REG_ADDR_W-1:0] rd_w_reg;
  logic                  regwrite_w_reg;

  // Memory wait-state FSM and bookkeeping
  mem_state_t            state_reg, state_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic                  mem_err_reg;
  logic [CNT_W-1:0]      stall_cnt_reg;

  logic                  mem_stall;
  logic                  mem_timeout;
  logic                  lw_stall;
  logic                  flush_e;
  logic                  load_d;

  assign load_d = (ResultSrcD_i == 2'b01);

  // ---------------------------------------------------------------------------
  // Forwarding: one identical selector per E-stage source operand.
  // The M stage holds the younger result, so it wins over W.
  // ---------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] src_e [2];
  logic [1:0]            fwd_sel [2];

  assign src_e[0] = rs1_e_reg;
  assign src_e[1] = rs2_e_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (regwrite_m_reg && (rd_m_reg != '0) && (rd_m_reg == src_e[gi])) begin
          fwd_sel[gi] = 2'b10;
        end else if (regwrite_w_reg && (rd_w_reg != '0) && (rd_w_reg == src_e[gi])) begin
          fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign ForwardAE_o = fwd_sel[0];
  assign ForwardBE_o = fwd_sel[1];

  // A load in E whose result is needed by D cannot be forwarded in time:
  // hold F/D for one cycle and push a bubble into E.
  assign lw_stall = load_e_reg && regwrite_e_reg && (rd_e_reg != '0) &&
                    ((rd_e_reg == Rs1D_i) || (rd_e_reg == Rs2D_i));

  // ---------------------------------------------------------------------------
  // Memory wait-state FSM (next-state / outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    mem_stall   = 1'b0;
    mem_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        // An access answered in the same cycle needs no wait state.
        if (MemAccessM_i && !MemReadyM_i) begin
          state_next = WAIT;
          timer_next = '0;
          mem_stall  = 1'b1;
        end
      end
      WAIT: begin
        // Completion has priority over the timeout in the same cycle.
        if (MemReadyM_i) begin
          state_next = IDLE;
        end else if (timer_reg == TMR_W'(MEM_TIMEOUT)) begin
          state_next  = IDLE;
          mem_timeout = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
          mem_stall  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // A memory stall freezes everything up to M; a branch or load-use flush is
  // withheld until it releases and is then re-evaluated from the held state.
  assign flush_e = !mem_stall && (BranchTakenE_i || lw_stall);

  // ---------------------------------------------------------------------------
  // Shadow pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e_reg      <= '0;
      rs2_e_reg      <= '0;
      rd_e_reg       <= '0;
      regwrite_e_reg <= 1'b0;
      load_e_reg     <= 1'b0;
      rd_m_reg       <= '0;
      regwrite_m_reg <= 1'b0;
      rd_w_reg       <= '0;
      regwrite_w_reg <= 1'b0;
    end else begin
      if (flush_e) begin
        rs1_e_reg      <= '0;
        rs2_e_reg      <= '0;
        rd_e_reg       <= '0;
        regwrite_e_reg <= 1'b0;
        load_e_reg     <= 1'b0;
      end else if (!mem_stall) begin
        rs1_e_reg      <= Rs1D_i;
        rs2_e_reg      <= Rs2D_i;
        rd_e_reg       <= RdD_i;
        regwrite_e_reg <= RegWriteD_i;
        load_e_reg     <= load_d;
      end

      if (!mem_stall) begin
        rd_m_reg       <= rd_e_reg;
        regwrite_m_reg <= regwrite_e_reg;
      end

      // While M is held, W receives a bubble so nothing is written twice.
      if (mem_stall) begin
        rd_w_reg       <= '0;
        regwrite_w_reg <= 1'b0;
      end else begin
        rd_w_reg       <= rd_m_reg;
        regwrite_w_reg <= regwrite_m_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag and stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (mem_timeout) begin
        mem_err_reg <= 1'b1;
      end
      if (mem_stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign mem_err_o   = mem_err_reg;
  assign stall_cnt_o = stall_cnt_reg;

  // Controls are forced low while reset is held, even if the memory inputs
  // are still asserted.
  assign StallF_o = rst_n && (mem_stall || lw_stall);
  assign StallD_o = rst_n && (mem_stall || lw_stall);
  assign StallE_o = rst_n && mem_stall;
  assign StallM_o = rst_n && mem_stall;
  assign FlushD_o = rst_n && !mem_stall && BranchTakenE_i;
  assign FlushE_o = rst_n && flush_e;
  assign FlushW_o = rst_n && mem_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] rs1_d, rs2_d, rd_d;
  logic          rw_d;
  logic [1:0]    src_d;
  logic          br_e, acc_m, rdy_m;
  logic [1:0]    fa, fb;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic          mem_err;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(rs1_d), .Rs2D_i(rs2_d), .RdD_i(rd_d), .RegWriteD_i(rw_d),
    .ResultSrcD_i(src_d), .BranchTakenE_i(br_e),
    .MemAccessM_i(acc_m), .MemReadyM_i(rdy_m),
    .ForwardAE_o(fa), .ForwardBE_o(fb),
    .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e), .StallM_o(stall_m),
    .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushW_o(flush_w),
    .mem_err_o(mem_err), .stall_cnt_o(stall_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model: instructions in flight as records, memory as a count of
  // consecutive cycles the current access has been waiting.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [RW-1:0] rs1, rs2, rd;
    logic          rw, ld;
  } instr_t;

  instr_t m_pipe [3];   // 0 = E, 1 = M, 2 = W
  int     m_waited;
  int     m_cnt;
  bit     m_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0]    s_fa, s_fb;
  logic [6:0]    s_ctrl;
  logic [CW-1:0] s_cnt;
  logic          s_err;

  wire [6:0] ctrl_now = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [RW-1:0] s);
    if (m_pipe[1].rw && m_pipe[1].rd != 0 && m_pipe[1].rd == s) return 2'b10;
    if (m_pipe[2].rw && m_pipe[2].rd != 0 && m_pipe[2].rd == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    instr_t bub;
    bub = '{default: '0};
    for (int i = 0; i < 3; i++) m_pipe[i] = bub;
    m_waited = 0;
    m_cnt    = 0;
    m_err    = 0;
  endtask

  // One clock cycle: starts just after a falling edge, drives inputs, checks
  // outputs against the model, advances the model at the rising edge.
  task automatic step(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                      input logic [RW-1:0] rd, input logic rw, input logic [1:0] src,
                      input logic br, input logic acc, input logic rdy);
    bit lw, ms, tmo;
    logic [6:0] ectrl;
    instr_t din, bub;
    bub = '{default: '0};
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; rw_d = rw; src_d = src;
    br_e = br; acc_m = acc; rdy_m = rdy;
    if (m_waited == 0) ms = acc && !rdy;
    else               ms = !rdy && (m_waited <= TO);
    tmo = (m_waited > TO) && !rdy;
    lw  = m_pipe[0].ld && m_pipe[0].rw && m_pipe[0].rd != 0 &&
          (m_pipe[0].rd == rs1 || m_pipe[0].rd == rs2);
    ectrl = {lw || ms, lw || ms, ms, ms, br && !ms, (br || lw) && !ms, ms};
    #1;
    s_fa = fa; s_fb = fb; s_ctrl = ctrl_now; s_cnt = stall_cnt; s_err = mem_err;
    chk("fwdA", s_fa, m_fwd(m_pipe[0].rs1));
    chk("fwdB", s_fb, m_fwd(m_pipe[0].rs2));
    chk("ctrl", s_ctrl, ectrl);
    chk("stall_cnt", s_cnt, m_cnt);
    chk("mem_err", s_err, m_err);
    @(posedge clk);
    if (ms) begin
      m_pipe[2] = bub;
      m_waited++;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      din = '{rs1, rs2, rd, rw, (src == 2'b01)};
      m_pipe[0] = (lw || br) ? bub : din;
      m_waited = 0;
      if (tmo) m_err = 1;
    end
    @(negedge clk);
  endtask

  // Assert reset (inputs left as they are), check outputs go low, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", ctrl_now, 0);
    chk("rst_fwdA", fa, 0);
    chk("rst_fwdB", fb, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_err", mem_err, 0);
    @(posedge clk);
    @(negedge clk);
    rs1_d = '0; rs2_d = '0; rd_d = '0; rw_d = 1'b0; src_d = 2'b00;
    br_e = 1'b0; acc_m = 1'b0; rdy_m = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed instruction-stream table: one entry per cycle.
  // ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [RW-1:0] rs1, rs2, rd;
    logic          rw;
    logic [1:0]    src;
    logic          br;
    logic [1:0]    fa, fb;
    logic [6:0]    ctrl;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input int rs1, input int rs2, input int rd, input bit rw,
                              input logic [1:0] src, input bit br,
                              input logic [1:0] efa, input logic [1:0] efb,
                              input logic [6:0] ectrl);
    vec_t v;
    v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.rd = RW'(rd); v.rw = rw;
    v.src = src; v.br = br; v.fa = efa; v.fb = efb; v.ctrl = ectrl;
    return v;
  endfunction

  initial begin
    int pct;
    rst_n = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; rw_d = 1'b0; src_d = 2'b00;
    br_e = 1'b0; acc_m = 1'b0; rdy_m = 1'b0;
    model_reset();

    tbl[0]  = mk(1, 2, 5, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000); // add x5,x1,x2
    tbl[1]  = mk(5, 3, 6, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000); // sub x6,x5,x3
    tbl[2]  = mk(4, 5, 7, 1, 2'b00, 0, 2'b10, 2'b00, 7'b0000000); // sub in E: A from M
    tbl[3]  = mk(9, 9, 0, 1, 2'b00, 0, 2'b00, 2'b01, 7'b0000000); // or in E: B from W
    tbl[4]  = mk(0, 0, 10, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000);
    tbl[5]  = mk(1, 0, 5, 1, 2'b01, 0, 2'b00, 2'b00, 7'b0000000); // lw x5; M has rd=x0
    tbl[6]  = mk(5, 1, 6, 1, 2'b00, 0, 2'b00, 2'b00, 7'b1100010); // load-use stall
    tbl[7]  = mk(5, 1, 6, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000); // bubble in E
    tbl[8]  = mk(6, 7, 0, 0, 2'b00, 0, 2'b01, 2'b00, 7'b0000000); // add in E: A from W (load)
    tbl[9]  = mk(6, 0, 11, 1, 2'b00, 1, 2'b10, 2'b00, 7'b0000110); // taken branch
    tbl[10] = mk(6, 6, 12, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000);
    tbl[11] = mk(1, 1, 13, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000);
    tbl[12] = mk(2, 2, 13, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000);
    tbl[13] = mk(13, 12, 14, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000);
    tbl[14] = mk(1, 0, 0, 1, 2'b01, 0, 2'b10, 2'b00, 7'b0000000); // M beats W
    tbl[15] = mk(0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 7'b0000000); // lw x0: no stall

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].src, tbl[i].br, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_fwdA", i), s_fa, tbl[i].fa);
      chk($sformatf("tbl%0d_fwdB", i), s_fb, tbl[i].fb);
      chk($sformatf("tbl%0d_ctrl", i), s_ctrl, tbl[i].ctrl);
    end

    // Slow memory: ready after 3 stall cycles, branch held during the stall.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step('0, '0, '0, 1'b0, 2'b00, (k > 0), 1'b1, 1'b0);
      chk($sformatf("slow%0d_ctrl", k), s_ctrl, 7'b1111001);
      chk($sformatf("slow%0d_cnt", k), s_cnt, k);
    end
    step('0, '0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("slow_release_ctrl", s_ctrl, 7'b0000110);
    chk("slow_release_cnt", s_cnt, 3);
    step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("slow_after_ctrl", s_ctrl, 7'b0000000);
    chk("slow_after_cnt", s_cnt, 3);

    // Timeout: one entry cycle plus 16 wait cycles stalled, then release.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      chk($sformatf("to%0d_ctrl", k), s_ctrl, 7'b1111001);
      chk($sformatf("to%0d_err", k), s_err, 0);
    end
    step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("to_release_ctrl", s_ctrl, 7'b0000000);
    chk("to_release_err", s_err, 0);
    for (int k = 0; k < 3; k++) begin
      step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_sticky%0d_err", k), s_err, 1);
      chk($sformatf("to_sticky%0d_cnt", k), s_cnt, 17);
    end

    // Reset in the middle of a wait state, memory inputs still asserted.
    do_reset();
    for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    do_reset();
    step('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("midwait_idle_ctrl", s_ctrl, 7'b0000000);
    chk("midwait_idle_cnt", s_cnt, 0);
    chk("midwait_idle_err", s_err, 0);

    // Randomized traffic against the model.
    do_reset();
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      logic br;
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 25;
          2: pct = 60;
          default: pct = 100;
        endcase
      end
      if (c % 1000 == 999) do_reset();
      br = ($urandom_range(0, 5) == 0) && !m_pipe[0].ld;
      step(RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), br,
           ($urandom_range(0, 2) != 0), (int'($urandom_range(0, 99)) < pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
